mux_n_arb: RTL and testbench



---
 rtl/mux_n_arb.sv | 222 ++++++++++++++++++++++
 tb/tb_mux_n_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_arb.sv
// mux_n_arb: packet-aware N:1 flit multiplexer with round-robin arbitration.
//
// Inputs that present a HEAD flit compete round-robin. The winner keeps the
// output until its TAIL flit has been forwarded. The output stage is a single
// valid/ready register. While no packet owns the output, any flit that is not
// a HEAD is stray: it is accepted, thrown away, and odrop pulses one cycle
// later.
//
// Flit type lives in the top TYPEW bits of each flit:
//   NONE=0, HEAD=1, DATA=2, TAIL=3.
//
// Optional build macro: MUX_N_ARB_STATIC_SEL_EN
//   When defined, a `sel` port is added. Only port `sel` can win arbitration
//   and the round-robin pointer stays at 0. `sel` is only looked at in the
//   cycle that grants a packet.

module mux_n_arb #(
  parameter int NPORT = 4,
  parameter int DATAW = 66,
  parameter int VCHW  = 2,
  parameter int TYPEW = 2,
  localparam int SELW = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT*DATAW-1:0] idata,
  input  logic [NPORT-1:0]       ivalid,
  input  logic [NPORT*VCHW-1:0]  ivch,
  output logic [NPORT-1:0]       iready,
  output logic [DATAW-1:0]       odata,
  output logic                   ovalid,
  output logic [VCHW-1:0]        ovch,
  input  logic                   oready,
  output logic                   odrop
`ifdef MUX_N_ARB_STATIC_SEL_EN
  ,
  input  logic [SELW-1:0]        sel
`endif
);

  localparam logic [TYPEW-1:0] TYPE_HEAD = TYPEW'(1);
  localparam logic [TYPEW-1:0] TYPE_TAIL = TYPEW'(3);

  // Round-robin pointer advance: one past the winner, wrapping at NPORT-1.
  function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] v);
    if (v == SELW'(NPORT - 1)) begin
      return '0;
    end else begin
      return v + SELW'(1);
    end
  endfunction

  // Architectural state.
  logic             lock_r;
  logic [SELW-1:0]  grant_r;
  logic [SELW-1:0]  rr_ptr_r;
  logic [DATAW-1:0] odata_r;
  logic [VCHW-1:0]  ovch_r;
  logic             ovalid_r;
  logic             odrop_r;

  // Per-port decode and arbitration results.
  logic [NPORT-1:0] head_s;
  logic [NPORT-1:0] stray_s;
  logic [NPORT-1:0] cand_s;
  logic             win_found_s;
  logic [SELW-1:0]  win_idx_s;
  int               scan_idx_s;

  // Handshake / load control.
  logic             can_load_s;
  logic [NPORT-1:0] iready_s;
  logic             drop_s;
  logic             acc_valid_s;
  logic [DATAW-1:0] acc_data_s;
  logic [VCHW-1:0]  acc_vch_s;
  logic             acc_tail_s;

  assign can_load_s = !ovalid_r || oready;
  assign acc_tail_s = (acc_data_s[DATAW-1 -: TYPEW] == TYPE_TAIL);

  assign iready = iready_s;
  assign odata  = odata_r;
  assign ovalid = ovalid_r;
  assign ovch   = ovch_r;
  assign odrop  = odrop_r;

  // Classify each valid input flit as a HEAD (may compete) or a stray flit.
  always_comb begin
    head_s  = '0;
    stray_s = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (ivalid[p]) begin
        head_s[p]  = (idata[p*DATAW + DATAW - TYPEW +: TYPEW] == TYPE_HEAD);
        stray_s[p] = (idata[p*DATAW + DATAW - TYPEW +: TYPEW] != TYPE_HEAD);
      end else begin
        head_s[p]  = 1'b0;
        stray_s[p] = 1'b0;
      end
    end
  end

  // Restrict which HEADs may win: all of them, or only the statically selected port.
  always_comb begin
    cand_s = '0;
    for (int p = 0; p < NPORT; p++) begin
`ifdef MUX_N_ARB_STATIC_SEL_EN
      cand_s[p] = head_s[p] && (SELW'(p) == sel);
`else
      cand_s[p] = head_s[p];
`endif
    end
  end

  // Pick the first candidate starting at rr_ptr and wrapping around.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_idx_s  = 0;
    for (int i = 0; i < NPORT; i++) begin
      scan_idx_s = (int'(rr_ptr_r) + i) % NPORT;
      if (!win_found_s && cand_s[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = SELW'(scan_idx_s);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Decide which ports are accepted this cycle and which flit (if any) loads the output.
  always_comb begin
    iready_s    = '0;
    drop_s      = 1'b0;
    acc_valid_s = 1'b0;
    acc_data_s  = '0;
    acc_vch_s   = '0;
    if (rst) begin
      iready_s = '0;
    end else if (lock_r) begin
      // Only the packet owner may move; everybody else stalls.
      iready_s[grant_r] = can_load_s;
      if (can_load_s && ivalid[grant_r]) begin
        acc_valid_s = 1'b1;
        acc_data_s  = idata[int'(grant_r)*DATAW +: DATAW];
        acc_vch_s   = ivch[int'(grant_r)*VCHW +: VCHW];
      end else begin
        acc_valid_s = 1'b0;
      end
    end else begin
      // Unlocked: strays are discarded regardless of output backpressure.
      iready_s = stray_s;
      drop_s   = |stray_s;
      if (win_found_s && can_load_s) begin
        iready_s[win_idx_s] = 1'b1;
        acc_valid_s = 1'b1;
        acc_data_s  = idata[int'(win_idx_s)*DATAW +: DATAW];
        acc_vch_s   = ivch[int'(win_idx_s)*VCHW +: VCHW];
      end else begin
        acc_valid_s = 1'b0;
      end
    end
  end

  // Output register: load an accepted flit, drain when consumed, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      odata_r  <= '0;
      ovch_r   <= '0;
      ovalid_r <= 1'b0;
    end else if (can_load_s) begin
      if (acc_valid_s) begin
        odata_r  <= acc_data_s;
        ovch_r   <= acc_vch_s;
        ovalid_r <= 1'b1;
      end else begin
        ovalid_r <= 1'b0;
      end
    end else begin
      odata_r  <= odata_r;
      ovch_r   <= ovch_r;
      ovalid_r <= ovalid_r;
    end
  end

  // Drop indicator: one-cycle pulse after any stray flit was discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      odrop_r <= 1'b0;
    end else begin
      odrop_r <= drop_s;
    end
  end

  // Packet lock: grab on an accepted HEAD while unlocked, release on an accepted TAIL.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_r   <= 1'b0;
      grant_r  <= '0;
      rr_ptr_r <= '0;
    end else if (lock_r) begin
      if (acc_valid_s && acc_tail_s) begin
        lock_r <= 1'b0;
      end else begin
        lock_r <= 1'b1;
      end
    end else if (acc_valid_s) begin
      lock_r  <= 1'b1;
      grant_r <= win_idx_s;
`ifdef MUX_N_ARB_STATIC_SEL_EN
      rr_ptr_r <= '0;
`else
      rr_ptr_r <= wrap_inc(win_idx_s);
`endif
    end else begin
      lock_r   <= lock_r;
      grant_r  <= grant_r;
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: tb/tb_mux_n_arb.sv
// Self-checking bench for mux_n_arb: per-port flit sources, a scoreboard of
// expected output flits, and a monitor that pops and compares on every output
// transfer. Honours MUX_N_ARB_STATIC_SEL_EN when it is defined.

module tb_mux_n_arb;

  localparam int NPORT = 4;
  localparam int DATAW = 66;
  localparam int VCHW  = 2;
  localparam int TYPEW = 2;
  localparam int DEPTH = 64;

  localparam logic [1:0] T_HEAD = 2'd1;
  localparam logic [1:0] T_DATA = 2'd2;
  localparam logic [1:0] T_TAIL = 2'd3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NPORT*DATAW-1:0] idata;
  logic [NPORT-1:0]       ivalid;
  logic [NPORT*VCHW-1:0]  ivch;
  logic [NPORT-1:0]       iready;
  logic [DATAW-1:0]       odata;
  logic                   ovalid;
  logic [VCHW-1:0]        ovch;
  logic                   oready;
  logic                   odrop;
`ifdef MUX_N_ARB_STATIC_SEL_EN
  logic [1:0]             sel;
`endif

  always #5 clk = ~clk;

  mux_n_arb #(.NPORT(NPORT), .DATAW(DATAW), .VCHW(VCHW), .TYPEW(TYPEW)) dut (
    .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .iready(iready), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .oready(oready), .odrop(odrop)
`ifdef MUX_N_ARB_STATIC_SEL_EN
    , .sel(sel)
`endif
  );

  // Sources and scoreboard.
  logic [DATAW-1:0] src_mem [NPORT][DEPTH];
  int               src_wr  [NPORT];
  int               src_rd  [NPORT];
  logic [VCHW+DATAW-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  logic [NPORT-1:0] last_iready;
  logic [NPORT-1:0] acc_mask;
  logic             drive_oready = 1'b1;

  task automatic chk(input string name, input logic [VCHW+DATAW-1:0] act,
                     input logic [VCHW+DATAW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATAW-1:0] mkflit(input logic [1:0] t, input int p,
                                              input logic [7:0] id, input int i);
    if (t == T_HEAD) begin
      return {t, 8'(p), id, 40'h0, 8'(i)};
    end else begin
      return {t, 8'(p), id, 48'(i)};
    end
  endfunction

  // Queue a packet (HEAD, ndata DATA, TAIL) on port p; optionally expect it on the output.
  task automatic add_pkt(input int p, input int ndata, input logic [7:0] dest,
                         input logic [7:0] id, input bit exp_out);
    logic [DATAW-1:0] f;
    for (int i = 0; i < ndata + 2; i++) begin
      if (i == 0) f = mkflit(T_HEAD, p, id, int'(dest));
      else if (i == ndata + 1) f = mkflit(T_TAIL, p, id, i);
      else f = mkflit(T_DATA, p, id, i);
      src_mem[p][src_wr[p]] = f;
      src_wr[p]++;
      if (exp_out) exp_q.push_back({2'(p), f});
    end
  endtask

  // One clock cycle: drive sources at negedge, note handshakes, advance past posedge.
  task automatic step();
    @(negedge clk);
    for (int p = 0; p < NPORT; p++) begin
      ivch[p*VCHW +: VCHW] = 2'(p);
      if (src_rd[p] < src_wr[p]) begin
        ivalid[p] = 1'b1;
        idata[p*DATAW +: DATAW] = src_mem[p][src_rd[p]];
      end else begin
        ivalid[p] = 1'b0;
        idata[p*DATAW +: DATAW] = '0;
      end
    end
    oready = drive_oready;
    #1;
    last_iready = iready;
    acc_mask = iready & ivalid;
    @(posedge clk);
    for (int p = 0; p < NPORT; p++) begin
      if (acc_mask[p]) src_rd[p]++;
    end
    #1;
  endtask

  task automatic run_until_empty(input string name, input int max, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d_left required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every output transfer must match the scoreboard head.
  initial begin
    logic [VCHW+DATAW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && ovalid === 1'b1 && oready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0h required=none", {ovch, odata});
        end else begin
          e = exp_q.pop_front();
          chk("sb_flit", {ovch, odata}, e);
        end
      end
    end
  end

  initial begin
    int n;
    int base;
    logic [DATAW-1:0] d5;
    rst = 1'b1;
    ivalid = '0;
    idata = '0;
    ivch = '0;
    oready = 1'b0;
`ifdef MUX_N_ARB_STATIC_SEL_EN
    sel = 2'd0;
`endif
    for (int p = 0; p < NPORT; p++) begin
      src_wr[p] = 0;
      src_rd[p] = 0;
    end

    // Reset held two cycles under random inputs.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      ivalid = 4'($urandom);
      oready = 1'($urandom);
      for (int p = 0; p < NPORT; p++) begin
        idata[p*DATAW +: DATAW] = DATAW'({$urandom, $urandom, $urandom});
        ivch[p*VCHW +: VCHW] = 2'($urandom);
      end
      #1;
      chk("rst_iready", 68'(iready), 68'(0));
      @(posedge clk);
      #1;
      chk("rst_ovalid", 68'(ovalid), 68'(0));
      chk("rst_odata", 68'(odata), 68'(0));
      chk("rst_odrop", 68'(odrop), 68'(0));
    end
    rst = 1'b0;

`ifndef MUX_N_ARB_STATIC_SEL_EN
    // Simultaneous HEADs on ports 0 and 1: port 0 first, then port 1, no gaps.
    add_pkt(0, 20, 8'h09, 8'h01, 1'b1);
    add_pkt(1, 20, 8'h04, 8'h02, 1'b1);
    run_until_empty("two_pkt", 200, n);
    chk("two_pkt_cycles", 68'(n), 68'(45));

    // Round robin: pointer now 2, so ports 3, 0, 1 in that order.
    add_pkt(3, 1, 8'h33, 8'h03, 1'b1);
    add_pkt(0, 1, 8'h30, 8'h04, 1'b1);
    add_pkt(1, 1, 8'h31, 8'h05, 1'b1);
    run_until_empty("rr_order", 100, n);
    chk("rr_cycles", 68'(n), 68'(10));
`endif

    // Stray DATA flit on port 2 while unlocked.
    src_mem[2][src_wr[2]] = mkflit(T_DATA, 2, 8'h06, 7);
    src_wr[2]++;
    step();
    chk("stray_iready2", 68'(last_iready[2]), 68'(1));
    chk("stray_odrop", 68'(odrop), 68'(1));
    chk("stray_ovalid", 68'(ovalid), 68'(0));
    step();
    chk("stray_odrop_clear", 68'(odrop), 68'(0));
    chk("stray_consumed", 68'(src_rd[2]), 68'(src_wr[2]));

    // Backpressure at DATA flit 5 of a port 0 packet.
`ifdef MUX_N_ARB_STATIC_SEL_EN
    sel = 2'd0;
`endif
    add_pkt(0, 8, 8'h11, 8'h07, 1'b1);
    d5 = mkflit(T_DATA, 0, 8'h07, 5);
    n = 0;
    while (!(ovalid === 1'b1 && odata === d5) && n < 50) begin
      step();
      n++;
    end
    chk("bp_reach_d5", 68'(odata), 68'(d5));
    drive_oready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_hold_odata", 68'(odata), 68'(d5));
      chk("bp_hold_ovalid", 68'(ovalid), 68'(1));
      chk("bp_iready", 68'(last_iready), 68'(0));
    end
    drive_oready = 1'b1;
    run_until_empty("bp_resume", 100, n);

    // Reset pulsed right after DATA flit 10 of a port 1 packet is accepted.
`ifdef MUX_N_ARB_STATIC_SEL_EN
    sel = 2'd1;
`endif
    base = src_rd[1];
    add_pkt(1, 15, 8'h22, 8'h08, 1'b1);
    n = 0;
    while (src_rd[1] < base + 11 && n < 50) begin
      step();
      n++;
    end
    chk("rmid_reach_d10", 68'(src_rd[1] - base), 68'(11));
    drive_oready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_ovalid", 68'(ovalid), 68'(0));
    chk("rmid_odata", 68'(odata), 68'(0));
    chk("rmid_iready", 68'(last_iready), 68'(0));
    exp_q.delete();
    src_rd[1] = src_wr[1];
    drive_oready = 1'b1;
`ifdef MUX_N_ARB_STATIC_SEL_EN
    sel = 2'd3;
`endif
    add_pkt(3, 2, 8'h44, 8'h09, 1'b1);
    run_until_empty("rmid_new", 50, n);
    chk("rmid_new_cycles", 68'(n), 68'(5));

`ifdef MUX_N_ARB_STATIC_SEL_EN
    // Static select 1: only port 1's packet moves, port 0 stays stalled.
    sel = 2'd1;
    base = src_rd[0];
    add_pkt(0, 3, 8'h50, 8'h0a, 1'b0);
    add_pkt(1, 3, 8'h51, 8'h0b, 1'b1);
    n = 0;
    while ((exp_q.size() != 0 || n < 8) && n < 50) begin
      step();
      n++;
      chk("sel_iready0", 68'(last_iready[0]), 68'(0));
    end
    chk("sel_done", 68'(exp_q.size()), 68'(0));
    chk("sel_port0_stalled", 68'(src_rd[0]), 68'(base));
    src_rd[0] = src_wr[0];
`endif

    step();
    step();
    chk("final_sb_empty", 68'(exp_q.size()), 68'(0));
    chk("final_ovalid", 68'(ovalid), 68'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
